// File: rtl/hamming_secded_stream_decoder_if.sv
// Valid/ready stream bundle for the SECDED decoder: codeword input side and decoded-result output side.
// Widths derive from DATA_W exactly as in the decoder, so both must be built with the same DATA_W.
interface hamming_secded_stream_decoder_if #(
    parameter int DATA_W = 11
);
    function automatic int calc_p(input int dw);
        int p;
        p = 1;
        for (int k = 1; k < 20; k++) begin
            if ((1 << k) < dw + k + 1) p = k + 1;
        end
        return p;
    endfunction

    localparam int P     = calc_p(DATA_W);
    localparam int N     = DATA_W + P + 1;
    localparam int POS_W = $clog2(N);

    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_code;
    logic              correct_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              single_err;
    logic              double_err;
    logic [POS_W-1:0]  err_pos;

    modport master (
        output in_valid, in_code, correct_en, out_ready,
        input  in_ready, out_valid, out_data, single_err, double_err, err_pos
    );

    modport slave (
        input  in_valid, in_code, correct_en, out_ready,
        output in_ready, out_valid, out_data, single_err, double_err, err_pos
    );
endinterface

// File: rtl/hamming_secded_stream_decoder.sv
// Two-stage pipelined extended-Hamming (SECDED) decoder on a valid/ready stream,
// with optional single-bit correction and saturating single/double error counters.
module hamming_secded_stream_decoder #(
    parameter int DATA_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    hamming_secded_stream_decoder_if.slave bus,
    input  logic                           clear_cnt,
    output logic [CNT_W-1:0]               single_cnt,
    output logic [CNT_W-1:0]               double_cnt
);
    function automatic int calc_p(input int dw);
        int p;
        p = 1;
        for (int k = 1; k < 20; k++) begin
            if ((1 << k) < dw + k + 1) p = k + 1;
        end
        return p;
    endfunction

    localparam int P     = calc_p(DATA_W);
    localparam int N     = DATA_W + P + 1;
    localparam int POS_W = $clog2(N);
    localparam logic [POS_W:0] N_EXT = (POS_W+1)'(N);

    function automatic logic [POS_W-1:0] syndrome(input logic [N-1:0] c);
        logic [POS_W-1:0] s;
        s = '0;
        for (int i = 1; i < N; i++) begin
            if (c[i]) s = s ^ POS_W'(i);
        end
        return s;
    endfunction

    // Data occupies every non-power-of-two index above 0, LSB first.
    function automatic logic [DATA_W-1:0] extract(input logic [N-1:0] c);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 3; i < N; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = c[i];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic              adv1, adv2, fire;
    logic              vld_p1;
    logic [N-1:0]      code_p1;
    logic [POS_W-1:0]  syn_p1;
    logic              par_p1, cen_p1;
    logic              vld_p2;
    logic [DATA_W-1:0] data_p2;
    logic              single_p2, double_p2;
    logic [POS_W-1:0]  pos_p2;

    logic [N-1:0]      fixed_code;
    logic              cls_single, cls_double;
    logic [POS_W-1:0]  cls_pos;
    logic [DATA_W-1:0] cls_data;

    assign adv2         = !vld_p2 || bus.out_ready;
    assign adv1         = !vld_p1 || adv2;
    assign fire         = vld_p2 && bus.out_ready;
    assign bus.in_ready = adv1;

    // Stage 1: syndrome and overall parity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (adv1) begin
            vld_p1 <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv1 && bus.in_valid) begin
            code_p1 <= bus.in_code;
            syn_p1  <= syndrome(bus.in_code);
            par_p1  <= ^bus.in_code;
            cen_p1  <= bus.correct_en;
        end
    end

    always_comb begin
        fixed_code = code_p1;
        cls_single = 1'b0;
        cls_double = 1'b0;
        cls_pos    = '0;
        if (par_p1) begin
            if (syn_p1 == '0) begin
                cls_single = 1'b1;
            end else if ({1'b0, syn_p1} < N_EXT) begin
                cls_single = 1'b1;
                cls_pos    = syn_p1;
                if (cen_p1) fixed_code[syn_p1] = ~code_p1[syn_p1];
            end else begin
                cls_double = 1'b1;
            end
        end else if (syn_p1 != '0) begin
            cls_double = 1'b1;
        end
        cls_data = extract(fixed_code);
    end

    // Stage 2: classification and data extraction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            data_p2   <= '0;
            single_p2 <= 1'b0;
            double_p2 <= 1'b0;
            pos_p2    <= '0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2   <= cls_data;
                single_p2 <= cls_single;
                double_p2 <= cls_double;
                pos_p2    <= cls_pos;
            end
        end
    end

    assign bus.out_valid  = vld_p2;
    assign bus.out_data   = data_p2;
    assign bus.single_err = single_p2;
    assign bus.double_err = double_p2;
    assign bus.err_pos    = pos_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            single_cnt <= '0;
            double_cnt <= '0;
        end else if (clear_cnt) begin
            single_cnt <= '0;
            double_cnt <= '0;
        end else begin
            if (fire && single_p2) single_cnt <= sat_inc(single_cnt);
            if (fire && double_p2) double_cnt <= sat_inc(double_cnt);
        end
    end
endmodule

// File: doc/hamming_secded_stream_decoder.md
Name: hamming_secded_stream_decoder

Overview:
- Parametrised, pipelined successor to the fixed 11-bit combinational SECDED decoder.
- Accepts extended-Hamming codewords of any data width over a valid/ready stream.
- Corrects single-bit errors (correction can be disabled) and flags double-bit errors.
- Keeps saturating error statistics. Sits between the noise channel or link receiver and the message consumer.

Parameters:
DATA_W, 11, message width in bits (>=4)
CNT_W, 16, width of each saturating error counter
(derived, not overridable) P = smallest integer with 2^P >= DATA_W+P+1; N = DATA_W+P+1 = codeword width; POS_W = clog2(N)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  codeword present
in_ready  out  1  decoder can accept codeword
in_code  in  N  received codeword
correct_en  in  1  1 = apply single-bit correction; sampled with in_code
out_valid  out  1  decoded result present
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  decoded message
single_err  out  1  single error detected (corrected if correct_en was 1)
double_err  out  1  uncorrectable error detected
err_pos  out  POS_W  flipped bit index when single_err, else 0
clear_cnt  in  1  synchronous counter clear
single_cnt  out  CNT_W  count of single_err results delivered
double_cnt  out  CNT_W  count of double_err results delivered

Behaviour:
- Codeword layout, index i in 0..N-1:
  - bit 0 = overall parity;
  - bits at i = 1,2,4,..,2^(P-1) = Hamming parity;
  - remaining indices ascending hold data, data LSB at the lowest index.
  - DATA_W=11 gives N=16, P=4.
- Stage 1 (registered) computes:
  - syndrome s = XOR of indices i in 1..N-1 whose bit is 1;
  - overall parity p = XOR of all N bits.
- Stage 1 registers in_code, s, p and correct_en.
- Stage 2 (registered) classifies the result:
  - p=0, s=0: clean; flags 0, err_pos 0.
  - p=1, s=0: single error at bit 0; single_err=1, err_pos=0; data unaffected.
  - p=1, 0<s<N: single error at index s; single_err=1, err_pos=s. If correct_en, flip bit s before extracting data; else output raw data bits.
  - p=1, s>=N: impossible single error; double_err=1, single_err=0, err_pos=0.
  - p=0, s!=0: double_err=1, err_pos=0; data extracted raw.
  - single_err and double_err are never both 1.
- Latency: 2 cycles from an in handshake to out_valid when out_ready is held 1. Throughput is 1 codeword/cycle.
- Handshake:
  - Stage k advances when it is empty or stage k+1 advances; stage 2 advances when !out_valid or out_ready.
  - in_ready = !v1 | !v2 | out_ready. It is combinational from out_ready; there is no combinational path from in_valid.
  - Outputs hold stable while out_valid=1 and out_ready=0. No codeword is dropped or duplicated.
- Counters:
  - Increment on out_valid&out_ready when the matching flag is 1.
  - Saturate at 2^CNT_W-1.
  - clear_cnt forces 0 next cycle and wins over a simultaneous increment.
- Reset: asynchronous assert clears v1, v2, out_valid, all flags, err_pos, out_data and both counters to 0. In-flight codewords are discarded. in_ready=1 the first cycle after deassert.

Test Plan:
1. Clean stream, DATA_W=11, out_ready=1: in_code 16'h0000 then 16'hFFFF -> out_data 11'h000 then 11'h7FF at +2 cycles; flags 0; counters unchanged.
2. Single error: in_code 16'h0020, correct_en=1 -> out_data 11'h000, single_err=1, err_pos=5, single_cnt=1. Same input with correct_en=0 -> single_err=1, out_data carries the raw flipped bit (data bit at index 5 = data[1], so 11'h002).
3. Parity-bit and overall-bit errors: 16'h0001 -> single_err=1, err_pos=0, out_data 11'h000. 16'hFFFE -> err_pos=0, out_data 11'h7FF.
4. Double error: 16'h0048 (bits 3,6) -> double_err=1, single_err=0, err_pos=0, double_cnt=1.
5. Backpressure:
   - Push 4 codewords back-to-back with out_ready=0 -> in_ready drops after 2 accepted; out_* stable.
   - Release out_ready -> all 4 emerge in order with correct data, none lost.
6. Counters and reset:
   - CNT_W=2, 5 single errors -> single_cnt saturates at 3.
   - clear_cnt coincident with an increment -> 0.
   - rst_n pulsed low with 2 codewords in flight -> out_valid=0 and counters 0 immediately; no stale output after release.
